// File: rtl/cla_adder_pkg.sv
// Shared types and sizing helpers for the sequential carry-look-ahead adder.
// Optional subtract mode is enabled with the CLA_ADDER_SUB_EN macro.
package cla_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of GROUP-bit slices in a WIDTH-bit word.
  function automatic int ng_f(input int width, input int group);
    return width / group;
  endfunction

  // Slice index width; a single-slice adder still needs a 1-bit index.
  function automatic int idx_w_f(input int ng);
    return (ng > 1) ? $clog2(ng) : 1;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-look-ahead slice: produces the sum, the
// carry out of the slice and the carry into its top bit (for overflow).
module cla_group
  import cla_adder_pkg::*;
#(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             cin_i,
  output logic [GROUP-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [GROUP-1:0] p_s;
  logic [GROUP-1:0] g_s;
  logic [GROUP:0]   c_s;
  logic             gg_s;
  logic             pp_s;

  // Prefix generate/propagate terms give every carry directly from cin.
  always_comb begin
    p_s  = a_i ^ b_i;
    g_s  = a_i & b_i;
    c_s  = '0;
    gg_s = 1'b0;
    pp_s = 1'b1;
    c_s[0] = cin_i;
    for (int i = 0; i < GROUP; i++) begin
      gg_s       = g_s[i] | (p_s[i] & gg_s);
      pp_s       = pp_s & p_s[i];
      c_s[i+1]   = gg_s | (pp_s & cin_i);
    end
    sum_o  = p_s ^ c_s[GROUP-1:0];
    cout_o = c_s[GROUP];
    cmsb_o = c_s[GROUP-1];
  end

endmodule

// File: rtl/cla_adder_seq.sv
// Multi-cycle CLA adder: one GROUP-bit slice per clock with a registered
// inter-slice carry. Define CLA_ADDER_SUB_EN to add the sub port.
module cla_adder_seq
  import cla_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG   = ng_f(WIDTH, GROUP);
  localparam int IDXW = idx_w_f(NG);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NG - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  b_eff_s;
  logic              cin_eff_s;
  logic [GROUP-1:0]  a_slice_s;
  logic [GROUP-1:0]  b_slice_s;
  logic [GROUP-1:0]  grp_sum_s;
  logic              grp_cout_s;
  logic              grp_cmsb_s;

`ifdef CLA_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; cin has no effect in that mode.
  assign b_eff_s   = sub ? ~b : b;
  assign cin_eff_s = sub ? 1'b1 : cin;
`else
  assign b_eff_s   = b;
  assign cin_eff_s = cin;
`endif

  assign a_slice_s = a_q[int'(idx_q) * GROUP +: GROUP];
  assign b_slice_s = b_q[int'(idx_q) * GROUP +: GROUP];

  cla_group #(
    .GROUP (GROUP)
  ) u_cla_group (
    .a_i    (a_slice_s),
    .b_i    (b_slice_s),
    .cin_i  (carry_q),
    .sum_o  (grp_sum_s),
    .cout_o (grp_cout_s),
    .cmsb_o (grp_cmsb_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b_eff_s;
          carry_d = cin_eff_s;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[int'(idx_q) * GROUP +: GROUP] = grp_sum_s;
        carry_d = grp_cout_s;
        if (idx_q == LAST_IDX) begin
          cout_d  = grp_cout_s;
          ovf_d   = grp_cmsb_s ^ grp_cout_s;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/cla_adder_seq.md
# cla_adder_seq

Multi-cycle, parametrised carry-look-ahead adder that adds two WIDTH-bit operands one GROUP-bit slice per clock, carrying between slices in a register. It generalises the team's fixed 8-bit CLA to arbitrary width with a valid/ready handshake on both sides, plus a signed-overflow flag. It sits between operand registers and result consumers in the datapath labs, and trades area for latency.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a positive multiple of GROUP
- GROUP, 8, bits processed per cycle by one CLA slice; NG = WIDTH/GROUP slices

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to bit 0
- sub  in  1  subtract mode (present only with CLA_ADDER_SUB_EN)
- out_valid  out  1  result held stable
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b (b inverted when sub=1), carry register <= effective carry-in, slice index <= 0, go RUN.
- RUN: each cycle the CLA slice adds a/b bits [idx*GROUP +: GROUP] with the carry register; writes that slice of sum, updates carry register with slice carry-out, idx++. After slice NG-1: cout <= slice carry-out, ovf <= carry into MSB XOR cout, go DONE.
- DONE: out_valid=1; sum/cout/ovf stable. On out_ready go IDLE. in_ready=0 in RUN and DONE; inputs ignored there.
- Arithmetic: modulo 2^WIDTH; cout is unsigned carry; ovf interprets operands as two's complement.
- Reset (any state, including mid-RUN): state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry register=0, idx=0; in-flight operation discarded.
- NG=1 is legal: RUN lasts exactly one cycle.

## Timing
- Accept edge T: out_valid rises at edge T+NG; sum fully valid with it.
- Consume edge (out_valid&&out_ready) at T+NG+k: in_ready rises the same edge; next accept earliest one cycle later.
- Minimum issue interval NG+2 cycles.
- out_valid/in_ready are registered-state decodes, never combinational from out_ready/in_valid.
- Reset values as in Operation, visible the cycle after rst sampled high.

## Configuration
- CLA_ADDER_SUB_EN defined: sub port exists; sub=1 latches ~b and forces effective carry-in to 1 (cin ignored); cout=1 means no borrow; ovf is signed subtract overflow.
- Undefined: no sub port; block always adds with cin; no inversion logic synthesised.

## Structure
- Package cla_adder_pkg: FSM state enum (IDLE/RUN/DONE), localparam helper for NG and index width ($clog2(NG) min 1).
- Sub-module cla_group: combinational GROUP-bit look-ahead slice (per-bit p/g, group carries, sum, carry-out, carry into top bit); one instance, reused every RUN cycle.
- Top holds FSM, operand/result registers, carry register, slice index.

## Test plan
- WIDTH=32,GROUP=8: a=0xFFFFFFFF, b=0x00000001, cin=0 -> out_valid after 4 cycles, sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- a=0x12345678, b=0x0F0F0F0F, cin=1 -> sum=0x21436588, cout=0; hold out_ready=0 5 cycles -> outputs stable, in_ready=0, new in_valid ignored.
- rst pulsed during RUN slice 2 -> next cycle out_valid=0, in_ready=1, sum=0; fresh op a=1,b=2,cin=0 -> sum=3.
- CLA_ADDER_SUB_EN, sub=1: a=5, b=7 -> sum=0xFFFFFFFE, cout=0; a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1.
- Back-to-back random ops with out_ready held 1 (WIDTH=16,GROUP=4 and GROUP=16) -> sum/cout/ovf match reference model; issue interval exactly NG+2.
